gpio_input_conditioner: RTL and testbench

Conditions the raw breakout-board inputs before any design logic consumes them. Sits directly downstream of the top-level wrapper: takes `gpio_in` and the synchronized `gated_reset`, and delivers metastability-safe, debounced pin levels plus single-cycle rise/fall event pulses and a sticky event flag to the design module.

---
 rtl/gpio_pkg.sv | 29 ++
 rtl/gpio_input_conditioner_debounce_cell.sv | 90 +++++++++
 rtl/gpio_input_conditioner.sv | 62 ++++++
 tb/tb_gpio_input_conditioner.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared constants, types and helpers for GPIO input
//               conditioning.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  localparam int GPIO_N_PINS           = 34;
  localparam int GPIO_DEBOUNCE_DEFAULT = 1000;

  // Debounce state is implicit: it is decoded each cycle from whether the
  // synchronized input disagrees with the accepted level.
  typedef enum logic {
    DBC_STABLE  = 1'b0,
    DBC_PENDING = 1'b1
  } dbc_state_e;

  // Counter width for a debounce length of d cycles. The counter only ever
  // needs to hold 0..d-1, and is never narrower than one bit.
  function automatic int dbc_width(input int d);
    int w;
    w = $clog2(d);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_input_conditioner_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module      : debounce_cell
// Description : One pin of the conditioner: 2-FF synchronizer, debounce
//               counter, accepted level and registered rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_cell
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic gated_reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             CNT_W    = dbc_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  dbc_state_e       state;

  // Two-flop synchronizer for the raw asynchronous pin.
  always_ff @(posedge clk or negedge gated_reset) begin
    if (!gated_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce decision: count while the synchronized input disagrees with the
  // accepted level; any agreement throws the partial count away.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    state   = (sync2_q == level_q) ? DBC_STABLE : DBC_PENDING;
    case (state)
      DBC_STABLE: begin
        cnt_d = '0;
      end
      DBC_PENDING: begin
        if (cnt_q == CNT_LAST) begin
          level_d = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Accepted level, counter and one-cycle event pulses.
  always_ff @(posedge clk or negedge gated_reset) begin
    if (!gated_reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : gpio_input_conditioner
// Description : Synchronizes and debounces raw GPIO inputs, produces per-pin
//               rise/fall pulses and sticky event flags.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int N_PINS          = GPIO_N_PINS,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              gated_reset,
  input  logic [N_PINS-1:0] gpio_in,
  input  logic              event_clr,
  output logic [N_PINS-1:0] pin_level,
  output logic [N_PINS-1:0] rise_pulse,
  output logic [N_PINS-1:0] fall_pulse,
  output logic [N_PINS-1:0] event_flag,
  output logic              any_event
);

  logic [N_PINS-1:0] event_flag_q, event_flag_d;

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk        (clk),
      .gated_reset(gated_reset),
      .pin_i      (gpio_in[i]),
      .level_o    (pin_level[i]),
      .rise_o     (rise_pulse[i]),
      .fall_o     (fall_pulse[i])
    );
  end

  // Sticky flags: clear first, then let a same-cycle event win.
  always_comb begin
    event_flag_d = event_flag_q;
    if (event_clr) begin
      event_flag_d = '0;
    end
    event_flag_d = event_flag_d | rise_pulse | fall_pulse;
  end

  // Flag register.
  always_ff @(posedge clk or negedge gated_reset) begin
    if (!gated_reset) begin
      event_flag_q <= '0;
    end else begin
      event_flag_q <= event_flag_d;
    end
  end

  assign event_flag = event_flag_q;
  assign any_event  = |event_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_input_conditioner
// Description : Self-checking bench for gpio_input_conditioner (4 pins,
//               debounce 4) plus a debounce-1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_input_conditioner;

  typedef struct packed {
    logic [3:0] g;
    logic       clr;
    logic [3:0] lvl;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] fl;
  } vec_t;

  logic       clk = 1'b0;
  logic       gated_reset = 1'b0;
  logic [3:0] gpio_in = 4'b0;
  logic       event_clr = 1'b0;
  logic [3:0] pin_level, rise_pulse, fall_pulse, event_flag;
  logic       any_event;

  logic [3:0] gpio1 = 4'b0;
  logic       clr1 = 1'b0;
  logic [3:0] lvl1, rise1, fall1, flag1;
  logic       any1;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  gpio_input_conditioner #(.N_PINS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .gated_reset(gated_reset), .gpio_in(gpio_in),
    .event_clr(event_clr), .pin_level(pin_level), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .event_flag(event_flag), .any_event(any_event)
  );

  gpio_input_conditioner #(.N_PINS(4), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .gated_reset(gated_reset), .gpio_in(gpio1),
    .event_clr(clr1), .pin_level(lvl1), .rise_pulse(rise1),
    .fall_pulse(fall1), .event_flag(flag1), .any_event(any1)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] g, input logic clr, input logic [3:0] lvl,
                     input logic [3:0] r, input logic [3:0] f, input logic [3:0] fl);
    vec_t v;
    v.g = g; v.clr = clr; v.lvl = lvl; v.r = r; v.f = f; v.fl = fl;
    vecs.push_back(v);
  endtask

  // Drive each row on the falling edge, compare just after the next rising edge.
  task automatic run_vectors(input string tag);
    vec_t v;
    vec_t e;
    int   row;
    row = 0;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      @(negedge clk);
      gpio_in   = v.g;
      event_clr = v.clr;
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s row %0d: scoreboard empty", tag, row);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s[%0d].pin_level", tag, row), pin_level, e.lvl);
        check($sformatf("%s[%0d].rise", tag, row), rise_pulse, e.r);
        check($sformatf("%s[%0d].fall", tag, row), fall_pulse, e.f);
        check($sformatf("%s[%0d].flag", tag, row), event_flag, e.fl);
        check($sformatf("%s[%0d].any", tag, row), {3'b0, any_event}, {3'b0, |e.fl});
      end
      row++;
    end
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset.pin_level", pin_level, 4'b0);
    check("reset.flag", event_flag, 4'b0);
    check("reset.any", {3'b0, any_event}, 4'b0);
    #1 gated_reset = 1'b1;

    // Step on pin 0: level after edge 5, pulse for one cycle, flag after edge 6
    for (int k = 0; k < 5; k++) add(4'b0001, 0, 4'b0000, 4'b0000, 4'b0, 4'b0000);
    add(4'b0001, 0, 4'b0001, 4'b0001, 4'b0, 4'b0000);
    add(4'b0001, 0, 4'b0001, 4'b0000, 4'b0, 4'b0001);
    add(4'b0001, 0, 4'b0001, 4'b0000, 4'b0, 4'b0001);
    run_vectors("step");

    // 3-cycle glitch on pin 1 rejected, then a 4-cycle hold accepted
    for (int k = 0; k < 3; k++) add(4'b0011, 0, 4'b0001, 4'b0, 4'b0, 4'b0001);
    for (int k = 0; k < 5; k++) add(4'b0001, 0, 4'b0001, 4'b0, 4'b0, 4'b0001);
    for (int k = 0; k < 5; k++) add(4'b0011, 0, 4'b0001, 4'b0, 4'b0, 4'b0001);
    add(4'b0011, 0, 4'b0011, 4'b0010, 4'b0, 4'b0001);
    add(4'b0011, 0, 4'b0011, 4'b0000, 4'b0, 4'b0011);
    add(4'b0011, 0, 4'b0011, 4'b0000, 4'b0, 4'b0011);
    run_vectors("glitch");

    // Pin 2 toggling every 2 cycles: no events; then held high: one rise
    for (int k = 0; k < 50; k++) begin
      logic tog;
      tog = ((k / 2) % 2) == 1;
      add({1'b0, tog, 2'b11}, 0, 4'b0011, 4'b0, 4'b0, 4'b0011);
    end
    for (int k = 0; k < 5; k++) add(4'b0111, 0, 4'b0011, 4'b0, 4'b0, 4'b0011);
    add(4'b0111, 0, 4'b0111, 4'b0100, 4'b0, 4'b0011);
    add(4'b0111, 0, 4'b0111, 4'b0000, 4'b0, 4'b0111);
    add(4'b0111, 0, 4'b0111, 4'b0000, 4'b0, 4'b0111);
    run_vectors("toggle");

    // Fall on pin 0 with event_clr coinciding with its flag update: set wins
    for (int k = 0; k < 5; k++) add(4'b0110, 0, 4'b0111, 4'b0, 4'b0, 4'b0111);
    add(4'b0110, 0, 4'b0110, 4'b0, 4'b0001, 4'b0111);
    add(4'b0110, 1, 4'b0110, 4'b0, 4'b0000, 4'b0001);
    add(4'b0110, 1, 4'b0110, 4'b0, 4'b0000, 4'b0000);
    add(4'b0110, 0, 4'b0110, 4'b0, 4'b0000, 4'b0000);
    run_vectors("clr");

    // Reset mid-count on pin 3 (counter at 2 after edge 3)
    @(negedge clk);
    gpio_in   = 4'b1110;
    event_clr = 1'b0;
    repeat (4) @(posedge clk);
    #2 gated_reset = 1'b0;
    #1;
    check("midreset.pin_level", pin_level, 4'b0);
    check("midreset.rise", rise_pulse, 4'b0);
    check("midreset.fall", fall_pulse, 4'b0);
    check("midreset.flag", event_flag, 4'b0);
    check("midreset.any", {3'b0, any_event}, 4'b0);
    repeat (2) @(posedge clk);
    #1;
    check("inreset.pin_level", pin_level, 4'b0);
    #1 gated_reset = 1'b1;
    for (int k = 0; k < 5; k++) add(4'b1110, 0, 4'b0000, 4'b0, 4'b0, 4'b0000);
    add(4'b1110, 0, 4'b1110, 4'b1110, 4'b0, 4'b0000);
    add(4'b1110, 0, 4'b1110, 4'b0000, 4'b0, 4'b1110);
    add(4'b1110, 0, 4'b1110, 4'b0000, 4'b0, 4'b1110);
    run_vectors("release");

    // Debounce-1 instance: level and pulse after edge 2
    @(negedge clk);
    gpio1 = 4'b0001;
    @(posedge clk); #1;
    check("d1.e0.pin_level", lvl1, 4'b0000);
    @(posedge clk); #1;
    check("d1.e1.pin_level", lvl1, 4'b0000);
    check("d1.e1.rise", rise1, 4'b0000);
    @(posedge clk); #1;
    check("d1.e2.pin_level", lvl1, 4'b0001);
    check("d1.e2.rise", rise1, 4'b0001);
    @(posedge clk); #1;
    check("d1.e3.rise", rise1, 4'b0000);
    check("d1.e3.fall", fall1, 4'b0000);
    check("d1.e3.flag", flag1, 4'b0001);
    check("d1.e3.any", {3'b0, any1}, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
